// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath.
// master = control unit (drives controls, reads opcode); slave = datapath side.
interface multicycle_main_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           opcode;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 pc_write_cond_n;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic                 zero_ext;
    logic [1:0]           pc_source;
    logic [3:0]           state;
    logic                 illegal_op;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, pc_write_cond_n, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, zero_ext, pc_source, state, illegal_op,
               instr_count, cycle_count
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, pc_write_cond_n, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, zero_ext, pc_source, state, illegal_op,
               instr_count, cycle_count
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath, with saturating
// retired-instruction and cycle counters for CPI measurement.
//
// state     | code | meaning
// FETCH     |  0   | read instruction, load IR, PC <= PC+4
// DECODE    |  1   | register read, branch target into ALUOut
// MEM_ADDR  |  2   | lw/sw effective address
// MEM_READ  |  3   | data memory read into MDR
// MEM_WB    |  4   | MDR -> rt
// MEM_WRITE |  5   | data memory write
// R_EXEC    |  6   | R-type ALU operation
// R_WB      |  7   | ALUOut -> rd
// BEQ       |  8   | compare, branch if equal
// JUMP      |  9   | PC <= jump target
// I_EXEC    | 10   | addi/andi ALU operation
// I_WB      | 11   | ALUOut -> rt
// BNE       | 12   | compare, branch if not equal
module multicycle_main_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_main_control_if.master  ctl
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BEQ       = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        BNE       = 4'd12
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instr_q, cycle_q;
    logic                 retire;

    logic       pc_write, pc_write_cond, pc_write_cond_n, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, zero_ext, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
            if (retire && instr_q != '1) instr_q <= instr_q + 1'b1;
        end
    end

    // Every terminal state of an instruction returns to FETCH unconditionally.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEM_WB, MEM_WRITE, R_WB, I_WB, BEQ, BNE, JUMP: retire = 1'b1;
            default:                                       retire = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = FETCH;
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        zero_ext        = 1'b0;
        pc_source       = 2'b00;
        illegal_op      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (ctl.opcode)
                    OP_LW, OP_SW:     state_d = MEM_ADDR;
                    OP_R:             state_d = R_EXEC;
                    OP_BEQ:           state_d = BEQ;
                    OP_BNE:           state_d = BNE;
                    OP_J:             state_d = JUMP;
                    OP_ADDI, OP_ANDI: state_d = I_EXEC;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (ctl.opcode == OP_LW)      state_d = MEM_READ;
                else if (ctl.opcode == OP_SW) state_d = MEM_WRITE;
                else                          state_d = FETCH;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            BNE: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_write_cond_n = 1'b1;
                pc_source       = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // andi zero-extends and uses the AND ALUop; addi sign-extends and adds.
                if (ctl.opcode == OP_ANDI) begin
                    alu_op   = 2'b11;
                    zero_ext = 1'b1;
                end
                state_d = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            pc_write        = 1'b0;
            pc_write_cond   = 1'b0;
            pc_write_cond_n = 1'b0;
            i_or_d          = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            ir_write        = 1'b0;
            mem_to_reg      = 1'b0;
            reg_dst         = 1'b0;
            reg_write       = 1'b0;
            alu_src_a       = 1'b0;
            alu_src_b       = 2'b00;
            alu_op          = 2'b00;
            zero_ext        = 1'b0;
            pc_source       = 2'b00;
            illegal_op      = 1'b0;
        end
    end

    assign ctl.pc_write        = pc_write;
    assign ctl.pc_write_cond   = pc_write_cond;
    assign ctl.pc_write_cond_n = pc_write_cond_n;
    assign ctl.i_or_d          = i_or_d;
    assign ctl.mem_read        = mem_read;
    assign ctl.mem_write       = mem_write;
    assign ctl.ir_write        = ir_write;
    assign ctl.mem_to_reg      = mem_to_reg;
    assign ctl.reg_dst         = reg_dst;
    assign ctl.reg_write       = reg_write;
    assign ctl.alu_src_a       = alu_src_a;
    assign ctl.alu_src_b       = alu_src_b;
    assign ctl.alu_op          = alu_op;
    assign ctl.zero_ext        = zero_ext;
    assign ctl.pc_source       = pc_source;
    assign ctl.illegal_op      = illegal_op;
    assign ctl.state           = state_q;
    assign ctl.instr_count     = instr_q;
    assign ctl.cycle_count     = cycle_q;

endmodule
